// File: rtl/sipo_deserializer_pkg.sv
// sipo_deserializer_pkg: shared state encoding and bit-count sizing for the deserializer.
package sipo_deserializer_pkg;
  typedef enum logic {IDLE, SHIFT} state_e;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if: serial input, parallel output handshake and status bundle.
interface sipo_deserializer_if #(parameter int WIDTH = 8);
  logic serial_in, serial_en, frame_start, out_ready, overflow_clr;
  logic [WIDTH-1:0] out_data;
  logic out_valid, busy, overflow, frame_error;
  modport master (
    output serial_in, serial_en, frame_start, out_ready, overflow_clr,
    input  out_data, out_valid, busy, overflow, frame_error
  );
  modport slave (
    input  serial_in, serial_en, frame_start, out_ready, overflow_clr,
    output out_data, out_valid, busy, overflow, frame_error
  );
endinterface

// File: rtl/sipo_out_buffer.sv
// sipo_out_buffer: one-entry valid/ready output register with sticky overflow on dropped writes.
module sipo_out_buffer #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overflow
);
  logic [WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, ovf_q, ovf_d, accept;
  always_comb begin
    accept  = wr_en && (!valid_q || rd_ready);
    data_d  = accept ? wr_data : data_q;
    valid_d = accept || (valid_q && !rd_ready);
    ovf_d   = (wr_en && !accept) || (ovf_q && !ovf_clr);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overflow  = ovf_q;
endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: strobed serial-to-parallel receiver with frame alignment and buffered output.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1,
  parameter bit CONTINUOUS = 1
) (
  input logic               clk,
  input logic               reset_n,
  sipo_deserializer_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic take, restart, done, busy, ferr_q, ferr_d;
  // Stale bits left by an aborted frame are fully shifted out before the word completes.
  always_comb begin
    busy     = state_q == SHIFT && cnt_q != '0;
    restart  = bus.serial_en && bus.frame_start;
    take     = bus.serial_en && (state_q == SHIFT || bus.frame_start);
    sr_shift = MSB_FIRST ? {sr_q[WIDTH-2:0], bus.serial_in} : {bus.serial_in, sr_q[WIDTH-1:1]};
    cnt_inc  = bus.frame_start ? CW'(1) : cnt_q + CW'(1);
    done     = take && cnt_inc == CW'(WIDTH);
    cnt_d    = take ? (done ? '0 : cnt_inc) : cnt_q;
    sr_d     = take ? sr_shift : sr_q;
    state_d  = (done && !CONTINUOUS) ? IDLE : take ? SHIFT : state_q;
    ferr_d   = restart && busy;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      ferr_q  <= ferr_d;
    end
  sipo_out_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk,
    .reset_n,
    .wr_en    (done),
    .wr_data  (sr_shift),
    .rd_ready (bus.out_ready),
    .ovf_clr  (bus.overflow_clr),
    .out_data (bus.out_data),
    .out_valid(bus.out_valid),
    .overflow (bus.overflow)
  );
  assign bus.busy        = busy;
  assign bus.frame_error = ferr_q;
endmodule
